// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the memory-access pipeline stage.
// Provides the writeback-select and FSM state encodings, the EX/MEM payload
// struct and a small alignment helper.
package mem_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  // Writeback source select carried with each instruction
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  // Memory-access FSM states
  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // EX/MEM pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0]  alu_res;
    logic [XLEN-1:0]  rt_data;
    logic [REG_W-1:0] rd;
    logic             mem_en;
    logic             w_reg_en;
    logic             wb_sel;
  } ex_mem_t;

  // Word alignment check on the two address LSBs
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port.
//   req/we/addr/wdata : request side, driven by the pipeline (master)
//   ack/rdata         : completion side, driven by the memory (slave)
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, word load/store over a req/ack port,
// front-of-pipe stall while an access is outstanding, MEM/WB register, and the
// EX/MEM forwarding/hazard taps.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ex_*                  instruction fields from execute
//   dmem                  data-memory req/ack port (master side)
//   mem_stall             hold PC, IF/ID, ID/EX and EX/MEM (combinational on ack)
//   ex_mem_alu_res, mem_rd, mem_w_reg_en, mem_is_load   EX/MEM taps
//   wb_*                  MEM/WB register
//   mem_err               sticky misalign/timeout flag
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   ex_alu_res,
  input  logic [XLEN-1:0]   ex_rt_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_mem_en,
  input  logic              ex_w_reg_en,
  input  logic              ex_wb_sel,
  mem_stage_if.master       dmem,
  output logic              mem_stall,
  output logic [XLEN-1:0]   ex_mem_alu_res,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_w_reg_en,
  output logic              mem_is_load,
  output logic [XLEN-1:0]   wb_alu_res,
  output logic [XLEN-1:0]   wb_rdata,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_w_reg_en,
  output logic              wb_sel,
  output logic              mem_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  ex_mem_t           mr;
  state_e            state;
  logic [CNT_W-1:0]  cnt;

  logic is_store;
  logic is_load;
  logic has_acc;
  logic misaligned;
  logic issue;
  logic done;
  logic abort;
  logic stall_c;

  // Access decode and completion/abort detection for the EX/MEM contents
  always_comb begin
    is_store   = mr.mem_en;
    is_load    = (mr.wb_sel == WB_SEL_MEM) && !mr.mem_en;
    has_acc    = is_store || is_load;
    misaligned = has_acc && !is_aligned(mr.alu_res[1:0]);
    issue      = has_acc && !misaligned;
    done       = issue && dmem.ack;
    abort      = issue && !dmem.ack && (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT));
    stall_c    = issue && !done && !abort;
  end

  // Request is a direct decode of the held EX/MEM register, so it stays
  // stable while stalled and drops immediately on reset.
  assign dmem.req   = issue;
  assign dmem.we    = issue && is_store;
  assign dmem.addr  = mr.alu_res;
  assign dmem.wdata = mr.rt_data;

  assign mem_stall      = stall_c;
  assign ex_mem_alu_res = mr.alu_res;
  assign mem_rd         = mr.rd;
  assign mem_w_reg_en   = mr.w_reg_en;
  assign mem_is_load    = is_load;

  // Access FSM and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (issue && !dmem.ack) begin
            state <= S_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (done || abort) begin
            state <= S_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // EX/MEM register, frozen while the stage stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mr <= '0;
    end else if (!stall_c) begin
      mr.alu_res  <= ex_alu_res;
      mr.rt_data  <= ex_rt_data;
      mr.rd       <= ex_rd;
      mr.mem_en   <= ex_mem_en;
      mr.w_reg_en <= ex_w_reg_en;
      mr.wb_sel   <= ex_wb_sel;
    end
  end

  // MEM/WB register: retire completed/no-access instructions, otherwise bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_alu_res  <= '0;
      wb_rdata    <= '0;
      wb_rd       <= '0;
      wb_w_reg_en <= 1'b0;
      wb_sel      <= 1'b0;
    end else if (!has_acc || done) begin
      wb_alu_res  <= mr.alu_res;
      wb_rdata    <= is_load ? dmem.rdata : '0;
      wb_rd       <= mr.rd;
      wb_w_reg_en <= mr.w_reg_en;
      wb_sel      <= mr.wb_sel;
    end else begin
      wb_alu_res  <= '0;
      wb_rdata    <= '0;
      wb_rd       <= '0;
      wb_w_reg_en <= 1'b0;
      wb_sel      <= 1'b0;
    end
  end

  // Sticky error, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err <= 1'b0;
    end else if (misaligned || abort) begin
      mem_err <= 1'b1;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, directly downstream of the execute stage. It holds the EX/MEM pipeline register and performs word loads/stores over a req/ack data-memory port. It stalls the front of the pipeline while an access is outstanding and produces the registered MEM/WB fields. It also drives the EX/MEM-side forwarding and hazard signals consumed by the execute stage and the hazard unit.

## Interface
Parameters:
- TIMEOUT, 16, maximum cycles `dmem_req` may stay high without `dmem_ack` before the access is aborted (≥1)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_alu_res  in  32  ALU result; memory byte address for loads/stores
- ex_rt_data  in  32  store data
- ex_rd  in  5  destination register
- ex_mem_en  in  1  1 = store
- ex_w_reg_en  in  1  register write enable
- ex_wb_sel  in  1  1 = writeback from memory (load)
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  access complete this cycle; `dmem_rdata` valid
- dmem_rdata  in  32  load data
- mem_stall  out  1  hold PC, IF/ID, ID/EX and the EX/MEM register
- ex_mem_alu_res  out  32  EX/MEM ALU result, forwarding path
- mem_rd  out  5  EX/MEM rd, hazard unit
- mem_w_reg_en  out  1  EX/MEM write enable, hazard unit
- mem_is_load  out  1  EX/MEM holds a load, load-use detection
- wb_alu_res  out  32  MEM/WB ALU result
- wb_rdata  out  32  MEM/WB load data
- wb_rd  out  5  MEM/WB rd
- wb_w_reg_en  out  1  MEM/WB write enable
- wb_sel  out  1  MEM/WB writeback select
- mem_err  out  1  sticky error: misaligned access or timeout

## Operation
- EX/MEM register loads all `ex_*` inputs on every edge where `mem_stall` = 0. It holds while stalled.
- Access type of the EX/MEM contents:
  - store if `mem_en` = 1. Store has priority when both `mem_en` and `wb_sel` are set; `wb_rdata` is then 0.
  - load if `wb_sel` = 1 and `mem_en` = 0.
  - otherwise none.
- A misaligned access (address[1:0] ≠ 0) is not issued:
  - `dmem_req` = 0 and `mem_err` is set.
  - The instruction retires as a bubble (`wb_w_reg_en` = 0).
  - No stall.
- FSM states:
  - S_RUN:
    - Aligned access present: `dmem_req` = 1.
    - `dmem_ack` in the same cycle: complete and stay in S_RUN.
    - No ack: go to S_WAIT with the counter set to 1.
  - S_WAIT:
    - `dmem_req` held high; address, data and `we` stable.
    - `dmem_ack`: complete and go to S_RUN.
    - Counter = TIMEOUT without ack: abort. Set `mem_err`, retire a bubble, go to S_RUN.
    - Otherwise increment the counter.
- `mem_stall` = access issued and not completing/aborting this cycle (combinational on `dmem_ack`).
- MEM/WB register on every edge:
  - Completing or no-access instruction: copies EX/MEM fields; `wb_rdata` ← `dmem_rdata` for a load, else 0.
  - Stalled, aborted or misaligned: bubble (`wb_w_reg_en` = 0, `wb_rd` = 0, `wb_sel` = 0).
- `mem_err` is cleared only by reset.

## Timing
- Reset (asynchronous, any state including mid-access):
  - All outputs and registers go to 0; FSM to S_RUN; counter to 0.
  - Any pending access is dropped and `dmem_req` deasserts immediately.
- Non-memory instruction: one cycle in MEM, no stall.
- Access with ack in the issue cycle: zero stall cycles.
- Ack k cycles late: k stall cycles.
- Timeout: exactly TIMEOUT stall cycles, then `mem_stall` = 0 in the abort cycle.
- `dmem_req` never deasserts before ack or abort. Exactly one request per instruction; never re-issued after completion.
- Forwarding outputs reflect the EX/MEM register directly (no extra cycle).

## Structure
- Shared defines file: WB_SEL_MEM/WB_SEL_ALU and FSM state encodings S_RUN/S_WAIT, alongside the existing Hzd_Sel_* and RT_SEL_* defines.
- Counter width = $clog2(TIMEOUT+1).
- Single module; no sub-module needed. The FSM and counter are internal.

## Test plan
- ALU op: `ex_alu_res` = 0x1234, rd = 5, `w_reg_en` = 1 → two cycles later `wb_alu_res` = 0x1234, `wb_rd` = 5, `mem_stall` never high.
- Load at 0x40, ack in the same cycle with rdata 0xDEADBEEF → `dmem_req` = 1, `dmem_we` = 0, no stall; next cycle `wb_rdata` = 0xDEADBEEF, `wb_sel` = 1.
- Store 0xCAFEF00D to 0x80, ack after 3 cycles → 3 stall cycles; `dmem_addr`/`dmem_wdata` stable throughout; bubbles in MEM/WB during the stall.
- Load at 0x10, no ack, TIMEOUT = 4 → 4 stall cycles; abort; `mem_err` = 1; bubble retired; next instruction proceeds.
- Store at 0x42 → no `dmem_req`, `mem_err` = 1, no stall.
- `rst_n` low during S_WAIT → `dmem_req`, `mem_stall` and `mem_err` go to 0 asynchronously; after release the FSM is in S_RUN.
